// File: rtl/periph_pkg.sv
// Shared definitions for memory-mapped peripherals on the MEM-stage data bus:
// register offsets, TCON bit positions and the TCON payload struct.
package periph_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 5;

  // Register offsets within a 32-byte peripheral window
  localparam logic [OFF_W-1:0] OFF_TH      = 5'h00;
  localparam logic [OFF_W-1:0] OFF_TL      = 5'h04;
  localparam logic [OFF_W-1:0] OFF_TCON    = 5'h08;
  localparam logic [OFF_W-1:0] OFF_SYSTICK = 5'h14;

  // TCON bit indices
  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

  // TCON control/status bits; field order matches the bit indices above
  typedef struct packed {
    logic st;
    logic ie;
    logic en;
  } tcon_t;

  // Zero-extend TCON to a full bus word
  function automatic logic [DATA_W-1:0] tcon_word(input tcon_t t);
    return {(DATA_W-3)'(0), t};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by PRESCALE while enabled.
// Ports: clk, reset (async active-low), en (count enable),
//        tick (combinational, high on the last cycle of each PRESCALE period).
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned    PC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  logic [PC_W-1:0] pc_q, pc_d;

  assign tick = en && (pc_q == PC_LAST);

  // Counter held at 0 while disabled, wraps on tick
  always_comb begin
    pc_d = '0;
    if (en && !tick) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer with overflow interrupt for the MIPS data bus.
// Ports: clk, reset (async active-low),
//        MemRead/MemWrite/Address/WriteData (MEM-stage bus request),
//        ReadData (combinational load data, 0 unless a hitting read),
//        IRQ (level interrupt, mirrors TCON status bit).
module timer_irq_source
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              IRQ
);

  logic [DATA_W-1:0] th_q, th_d;
  logic [DATA_W-1:0] tl_q, tl_d;
  logic [DATA_W-1:0] systick_q, systick_d;
  tcon_t             tcon_q, tcon_d;

  logic             hit;
  logic [OFF_W-1:0] off;
  logic             wr_th, wr_tl, wr_tcon;
  logic             tick;
  logic             tl_at_max;
  logic             overflow;
  logic             unused_addr_bits;

  // Byte lanes are not decoded; accesses are treated as word accesses
  assign unused_addr_bits = ^Address[1:0];

  assign hit     = (Address[31:5] == BASE_ADDR[31:5]);
  assign off     = {Address[4:2], 2'b00};
  assign wr_th   = MemWrite && hit && (off == OFF_TH);
  assign wr_tl   = MemWrite && hit && (off == OFF_TL);
  assign wr_tcon = MemWrite && hit && (off == OFF_TCON);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tcon_q.en),
    .tick  (tick)
  );

  // A CPU write to TL suppresses both the increment and the overflow
  assign tl_at_max = (tl_q == '1);
  assign overflow  = tick && tl_at_max && !wr_tl;

  // Register next-state with write/overflow priority
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + DATA_W'(1);

    if (tick) begin
      tl_d = tl_at_max ? th_q : tl_q + DATA_W'(1);
    end
    if (wr_th) begin
      th_d = WriteData;
    end
    if (wr_tl) begin
      tl_d = WriteData;
    end
    if (wr_tcon) begin
      tcon_d.en = WriteData[TCON_EN];
      tcon_d.ie = WriteData[TCON_IE];
      if (WriteData[TCON_ST]) begin
        tcon_d.st = 1'b0;
      end
    end
    // Overflow set beats a same-cycle write-1-to-clear
    if (overflow && tcon_q.ie) begin
      tcon_d.st = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
    end
  end

  assign IRQ = tcon_q.st;

  // Read mux
  always_comb begin
    ReadData = '0;
    if (MemRead && hit) begin
      unique case (off)
        OFF_TH:      ReadData = th_q;
        OFF_TL:      ReadData = tl_q;
        OFF_TCON:    ReadData = tcon_word(tcon_q);
        OFF_SYSTICK: ReadData = systick_q;
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Testbench for timer_irq_source: two instances (PRESCALE=1 and PRESCALE=4)
// checked by directed scenarios and randomized bus traffic against a model.
module tb_timer_irq_source;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        mr    [2];
  logic        mw    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        irq   [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #50 clk = ~clk;

  timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(1)) u_ps1 (
    .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]),
    .Address(addr[0]), .WriteData(wd[0]), .ReadData(rdata[0]), .IRQ(irq[0])
  );

  timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(4)) u_ps4 (
    .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]),
    .Address(addr[1]), .WriteData(wd[1]), .ReadData(rdata[1]), .IRQ(irq[1])
  );

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] sys;
    bit          en;
    bit          ie;
    bit          st;
    int          pc;
  } mstate_t;

  mstate_t m [2];

  // One clock of timer behaviour, given the bus write presented this cycle
  function automatic mstate_t model_next(input mstate_t s, input int ps, input logic we,
                                         input logic [31:0] a, input logic [31:0] d);
    mstate_t n = s;
    bit hit_w  = we && (a[31:5] == BASE[31:5]);
    int off    = int'({a[4:2], 2'b00});
    bit tick   = s.en && (s.pc == ps - 1);
    bit wrap   = tick && (s.tl == MAXV) && !(hit_w && off == 4);
    n.sys = s.sys + 32'd1;
    n.pc  = (s.en && !tick) ? s.pc + 1 : 0;
    if (tick) n.tl = (s.tl == MAXV) ? s.th : s.tl + 32'd1;
    if (hit_w) begin
      case (off)
        0: n.th = d;
        4: n.tl = d;
        8: begin
          n.en = d[0];
          n.ie = d[1];
          if (d[2]) n.st = 1'b0;
        end
        default: ;
      endcase
    end
    if (wrap && s.ie) n.st = 1'b1;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input mstate_t s, input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (int'({a[4:2], 2'b00}))
      0:       return s.th;
      4:       return s.tl;
      8:       return {29'd0, s.st, s.ie, s.en};
      20:      return s.sys;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
    end else begin
      m[0] <= model_next(m[0], 1, mw[0], addr[0], wd[0]);
      m[1] <= model_next(m[1], 4, mw[1], addr[1], wd[1]);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d);
    mw[k] = 1'b1; addr[k] = a; wd[k] = d;
    @(posedge clk);
    #1;
    mw[k] = 1'b0;
  endtask

  task automatic rd(input int k, input logic [31:0] a, output logic [31:0] v);
    mr[k] = 1'b1; addr[k] = a;
    #1;
    v = rdata[k];
    mr[k] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    #1 reset = 1'b0;
    #10;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (irq[k] !== 1'b0) begin errors++; $display("FAIL reset_irq k=%0d got %b exp 0", k, irq[k]); end
      for (int o = 0; o < 32; o += 4) begin
        rd(k, BASE + 32'(o), v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL reset_read k=%0d off=%0h got %h exp 0", k, o, v); end
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(7);
    for (int k = 0; k < 2; k++) begin
      rd(k, BASE + 32'h14, v);
      checks++;
      if (v !== 32'd7 && v !== 32'd6) begin errors++; $display("FAIL systick_after_reset k=%0d got %0d exp 6..7", k, v); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    wr(0, BASE + 32'h0, 32'hFFFF_FFF0);
    wr(0, BASE + 32'h4, 32'hFFFF_FFFE);
    wr(0, BASE + 32'h8, 32'd3);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL ovf_irq_edge0 got %b exp 0", irq[0]); end
    step(1);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL ovf_irq_edge1 got %b exp 0", irq[0]); end
    step(1);
    checks++;
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL ovf_irq_edge2 got %b exp 1", irq[0]); end
    rd(0, BASE + 32'h4, v);
    checks++;
    if (v !== 32'hFFFF_FFF0) begin errors++; $display("FAIL ovf_reload got %h exp fffffff0", v); end
  endtask

  task automatic test_w1c();
    logic [31:0] a, b;
    int n;
    wr(0, BASE + 32'h8, 32'h7);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL w1c_clear got %b exp 0", irq[0]); end
    rd(0, BASE + 32'h4, a);
    step(1);
    rd(0, BASE + 32'h4, b);
    checks++;
    if (b !== m[0].tl || a !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL w1c_running got %h,%h exp fffffff1,%h", a, b, m[0].tl);
    end
    n = 0;
    while (irq[0] !== 1'b1 && n < 40) begin step(1); n++; end
    checks++;
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL w1c_reoverflow timeout after %0d cycles exp irq 1", n); end
    wr(0, BASE + 32'h8, 32'h3);
    checks++;
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL w1c_zero_keeps got %b exp 1", irq[0]); end
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    wr(0, BASE + 32'h8, 32'h7);
    // TL write at the overflow edge
    wr(0, BASE + 32'h4, 32'hFFFF_FFFE);
    step(1);
    wr(0, BASE + 32'h4, 32'h1234_5678);
    rd(0, BASE + 32'h4, v);
    checks++;
    if (v !== 32'h1234_5678) begin errors++; $display("FAIL col_tl_value got %h exp 12345678", v); end
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL col_tl_irq got %b exp 0", irq[0]); end
    // TH write at the overflow edge
    wr(0, BASE + 32'h4, 32'hFFFF_FFFE);
    step(1);
    wr(0, BASE + 32'h0, 32'h0000_ABCD);
    rd(0, BASE + 32'h4, v);
    checks++;
    if (v !== 32'hFFFF_FFF0) begin errors++; $display("FAIL col_th_tl got %h exp fffffff0", v); end
    rd(0, BASE + 32'h0, v);
    checks++;
    if (v !== 32'h0000_ABCD) begin errors++; $display("FAIL col_th_th got %h exp 0000abcd", v); end
    checks++;
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL col_th_irq got %b exp 1", irq[0]); end
    // W1C at the overflow edge
    wr(0, BASE + 32'h4, 32'hFFFF_FFFE);
    step(1);
    wr(0, BASE + 32'h8, 32'h7);
    checks++;
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL col_w1c_irq got %b exp 1", irq[0]); end
    rd(0, BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_ABCD) begin errors++; $display("FAIL col_w1c_tl got %h exp 0000abcd", v); end
  endtask

  task automatic test_miss();
    logic [31:0] v;
    wr(0, BASE + 32'h8, 32'h4);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL miss_clear got %b exp 0", irq[0]); end
    wr(0, BASE + 32'h0, 32'h100);
    wr(0, BASE + 32'h20, 32'hDEAD);
    wr(0, BASE + 32'h0C, 32'hBEEF);
    wr(0, BASE + 32'h24, 32'h5);
    rd(0, BASE + 32'h0, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("FAIL miss_th got %h exp 00000100", v); end
    rd(0, BASE + 32'h4, v);
    checks++;
    if (v !== m[0].tl || v === 32'h5) begin errors++; $display("FAIL miss_tl got %h exp %h", v, m[0].tl); end
    rd(0, BASE + 32'h20, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL miss_read_20 got %h exp 0", v); end
    rd(0, BASE + 32'h0C, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL miss_read_0c got %h exp 0", v); end
    mr[0] = 1'b0; addr[0] = BASE; #1;
    checks++;
    if (rdata[0] !== 32'd0) begin errors++; $display("FAIL noread_zero got %h exp 0", rdata[0]); end
    wr(0, BASE + 32'h4, 32'hFFFF_FFFE);
    wr(0, BASE + 32'h8, 32'h1);
    step(2);
    rd(0, BASE + 32'h4, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("FAIL noie_reload got %h exp 00000100", v); end
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL noie_irq got %b exp 0", irq[0]); end
    rd(0, BASE + 32'hB, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL noie_tcon got %h exp 00000001", v); end
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    wr(1, BASE + 32'h4, 32'd0);
    wr(1, BASE + 32'h8, 32'd1);
    step(12);
    rd(1, BASE + 32'h4, v);
    checks++;
    if (v !== 32'd3) begin errors++; $display("FAIL ps4_count got %0d exp 3", v); end
    wr(1, BASE + 32'h8, 32'd0);
    step(10);
    rd(1, BASE + 32'h4, v);
    checks++;
    if (v !== 32'd3) begin errors++; $display("FAIL ps4_frozen got %0d exp 3", v); end
    wr(1, BASE + 32'h8, 32'd1);
    step(3);
    rd(1, BASE + 32'h4, v);
    checks++;
    if (v !== 32'd3) begin errors++; $display("FAIL ps4_reenable_early got %0d exp 3", v); end
    step(1);
    rd(1, BASE + 32'h4, v);
    checks++;
    if (v !== 32'd4) begin errors++; $display("FAIL ps4_reenable_first got %0d exp 4", v); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, e;
    int sel;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        sel = $urandom_range(0, 7);
        case (sel)
          0: a = BASE;
          1, 7: a = BASE + 32'h4;
          2: a = BASE + 32'h8;
          3: a = BASE + 32'h0C;
          4: a = BASE + 32'h14;
          5: a = BASE + 32'h1C;
          default: a = BASE + 32'h20 + 32'($urandom_range(0, 7) * 4);
        endcase
        a = a | 32'($urandom_range(0, 3));
        d = $urandom;
        if (sel == 1 || sel == 7) d = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
        if (sel == 2) d[0] = ($urandom_range(0, 3) != 0);
        addr[k] = a; wd[k] = d; mr[k] = 1'b1;
        mw[k] = ($urandom_range(0, 19) < 3);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        e = model_read(m[k], addr[k]);
        checks++;
        if (rdata[k] !== e) begin
          errors++; $display("FAIL rand_read k=%0d cyc=%0d addr=%h got %h exp %h", k, cyc, addr[k], rdata[k], e);
        end
        checks++;
        if (irq[k] !== m[k].st) begin
          errors++; $display("FAIL rand_irq k=%0d cyc=%0d got %b exp %b", k, cyc, irq[k], m[k].st);
        end
      end
      step(1);
    end
    for (int k = 0; k < 2; k++) begin mw[k] = 1'b0; mr[k] = 1'b0; end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    wr(0, BASE + 32'h8, 32'h3);
    step(3);
    #20 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (irq[k] !== 1'b0) begin errors++; $display("FAIL areset_irq k=%0d got %b exp 0", k, irq[k]); end
      rd(k, BASE + 32'h4, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL areset_tl k=%0d got %h exp 0", k, v); end
      rd(k, BASE + 32'h14, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL areset_systick k=%0d got %h exp 0", k, v); end
      rd(k, BASE + 32'h8, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL areset_tcon k=%0d got %h exp 0", k, v); end
    end
    #10 reset = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mr[k] = 1'b0; mw[k] = 1'b0; addr[k] = 32'd0; wd[k] = 32'd0;
    end
    test_reset();
    test_overflow();
    test_w1c();
    test_collisions();
    test_miss();
    test_prescale();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
